// File: rtl/psum_stage.sv
// Partial-sum stage: accumulates per-row SS beats into groups and presents each finished group on PS.
// Optional build macro PSUM_SAT_EN: row additions saturate to the signed range and flag o_err.
module psum_stage #(
  parameter int PEROW   = 4,
  parameter int PSUMDWD = 16,
  parameter int CNTWD   = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            SS_rdy,
  output logic                            SS_ack,
  input  logic [PEROW-1:0][PSUMDWD-1:0]   i_sum_SS,
  input  logic [1:0]                      i_ppctl_SS,
  output logic                            PS_rdy,
  input  logic                            PS_ack,
  output logic [PEROW-1:0][PSUMDWD-1:0]   o_psum_PS,
  output logic [CNTWD-1:0]                o_cnt_PS,
  output logic                            o_err,
  input  logic                            i_err_clr
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;

  // Returns {overflow, sum}; overflow is only reported when saturation is built in.
  function automatic logic [PSUMDWD:0] add_row(input logic [PSUMDWD-1:0] a,
                                               input logic [PSUMDWD-1:0] b);
    logic [PSUMDWD-1:0] s;
    logic               ovf;
    s   = a + b;
    ovf = (a[PSUMDWD-1] == b[PSUMDWD-1]) && (s[PSUMDWD-1] != a[PSUMDWD-1]);
`ifdef PSUM_SAT_EN
    if (ovf) begin
      s = a[PSUMDWD-1] ? {1'b1, {(PSUMDWD-1){1'b0}}} : {1'b0, {(PSUMDWD-1){1'b1}}};
    end else begin
      s = s;
    end
`else
    ovf = 1'b0;
`endif
    return {ovf, s};
  endfunction

  state_t                          state_r, state_nxt_s;
  logic [PEROW-1:0][PSUMDWD-1:0]   acc_r, acc_nxt_s, psum_r;
  logic [PSUMDWD:0]                row_res_s [PEROW];
  logic [CNTWD-1:0]                cnt_r, cnt_nxt_s, ocnt_r;
  logic                            ps_rdy_r, err_r;
  logic                            ss_ack_s, ss_hs_s, ps_hs_s, first_s, last_s, start_s;
  logic                            sat_any_s, cnt_max_s, err_set_s;

  // Handshakes, group start detection and next accumulator/counter values.
  always_comb begin
    ss_ack_s  = (state_r != OUT) || PS_ack;
    ss_hs_s   = SS_rdy && ss_ack_s;
    ps_hs_s   = ps_rdy_r && PS_ack;
    first_s   = i_ppctl_SS[1];
    last_s    = i_ppctl_SS[0];
    // Only an open group accumulates; a first bit inside it restarts the group.
    start_s   = (state_r != ACC) || first_s;
    cnt_max_s = (cnt_r == {CNTWD{1'b1}});
    sat_any_s = 1'b0;
    for (int i = 0; i < PEROW; i++) begin
      row_res_s[i] = add_row(acc_r[i], i_sum_SS[i]);
      sat_any_s    = sat_any_s | row_res_s[i][PSUMDWD];
    end
    if (start_s) begin
      acc_nxt_s = i_sum_SS;
      cnt_nxt_s = {{(CNTWD-1){1'b0}}, 1'b1};
    end else begin
      for (int i = 0; i < PEROW; i++) begin
        acc_nxt_s[i] = row_res_s[i][PSUMDWD-1:0];
      end
      cnt_nxt_s = cnt_max_s ? cnt_r : cnt_r + {{(CNTWD-1){1'b0}}, 1'b1};
    end
    err_set_s = ss_hs_s && ((state_r == ACC && first_s) ||
                            (!start_s && (cnt_max_s || sat_any_s)));
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    if (ss_hs_s) begin
      state_nxt_s = last_s ? OUT : ACC;
    end else if (ps_hs_s) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accumulator and beat counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (ss_hs_s) begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_nxt_s;
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  // Output group registers; a closing beat reloads them even while draining.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      psum_r   <= '0;
      ocnt_r   <= '0;
      ps_rdy_r <= 1'b0;
    end else if (ss_hs_s && last_s) begin
      psum_r   <= acc_nxt_s;
      ocnt_r   <= cnt_nxt_s;
      ps_rdy_r <= 1'b1;
    end else if (ps_hs_s) begin
      ps_rdy_r <= 1'b0;
    end else begin
      ps_rdy_r <= ps_rdy_r;
    end
  end

  // Sticky error flag; a new error beats a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else if (i_err_clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign SS_ack    = ss_ack_s;
  assign PS_rdy    = ps_rdy_r;
  assign o_psum_PS = psum_r;
  assign o_cnt_PS  = ocnt_r;
  assign o_err     = err_r;

endmodule

// File: tb/tb_psum_stage.sv
// Table-driven bench for psum_stage; rows 2/3 mirror rows 0/1 (row3 negated) to exercise every lane.
module tb_psum_stage;

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic                SS_rdy, SS_ack, PS_rdy, PS_ack, o_err, i_err_clr;
  logic [3:0][15:0]    i_sum_SS, o_psum_PS;
  logic [1:0]          i_ppctl_SS;
  logic [7:0]          o_cnt_PS;

  int n_vec = 0;
  int n_bad = 0;

  psum_stage #(.PEROW(4), .PSUMDWD(16), .CNTWD(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .SS_rdy(SS_rdy), .SS_ack(SS_ack),
    .i_sum_SS(i_sum_SS), .i_ppctl_SS(i_ppctl_SS), .PS_rdy(PS_rdy), .PS_ack(PS_ack),
    .o_psum_PS(o_psum_PS), .o_cnt_PS(o_cnt_PS), .o_err(o_err), .i_err_clr(i_err_clr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        rdy, f, l, ack, clr;
    logic [15:0] s0, s1;
    logic        x_ssack, x_rdy;
    logic [15:0] x_p0, x_p1;
    logic [7:0]  x_cnt;
    logic        x_err;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic rdy, f, l, ack, clr, input logic [15:0] s0, s1,
                              input logic x_ssack, x_rdy, input logic [15:0] x_p0, x_p1,
                              input logic [7:0] x_cnt, input logic x_err);
    vec_t v;
    v = '{rdy, f, l, ack, clr, s0, s1, x_ssack, x_rdy, x_p0, x_p1, x_cnt, x_err};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, f, l, ack, clr, input logic [15:0] s0, s1);
    SS_rdy      = rdy;
    i_ppctl_SS  = {f, l};
    PS_ack      = ack;
    i_err_clr   = clr;
    i_sum_SS[0] = s0;
    i_sum_SS[1] = s1;
    i_sum_SS[2] = s0;
    i_sum_SS[3] = -s1;
  endtask

  task automatic chk_out(input string tag, input logic x_rdy, input logic [15:0] x_p0, x_p1,
                         input logic [7:0] x_cnt, input logic x_err);
    chk({tag, ".ps_rdy"}, {31'd0, PS_rdy}, {31'd0, x_rdy});
    chk({tag, ".psum0"}, {16'd0, o_psum_PS[0]}, {16'd0, x_p0});
    chk({tag, ".psum1"}, {16'd0, o_psum_PS[1]}, {16'd0, x_p1});
    chk({tag, ".psum2"}, {16'd0, o_psum_PS[2]}, {16'd0, x_p0});
    chk({tag, ".psum3"}, {16'd0, o_psum_PS[3]}, {16'd0, -x_p1});
    chk({tag, ".cnt"}, {24'd0, o_cnt_PS}, {24'd0, x_cnt});
    chk({tag, ".err"}, {31'd0, o_err}, {31'd0, x_err});
  endtask

  // One clock: drive at negedge, check SS_ack before the edge, registered outputs after it.
  task automatic step(input string tag, input vec_t v);
    @(negedge i_clk);
    drive(v.rdy, v.f, v.l, v.ack, v.clr, v.s0, v.s1);
    #1;
    chk({tag, ".ss_ack"}, {31'd0, SS_ack}, {31'd0, v.x_ssack});
    @(posedge i_clk);
    #1;
    chk_out(tag, v.x_rdy, v.x_p0, v.x_p1, v.x_cnt, v.x_err);
  endtask

  logic [15:0] ovf_p0;
  logic        ovf_err;

  initial begin
`ifdef PSUM_SAT_EN
    ovf_p0 = 16'h7FFF; ovf_err = 1'b1;
`else
    ovf_p0 = 16'h8000; ovf_err = 1'b0;
`endif
    //          rdy   f     l     ack   clr   s0          s1          ssack rdy   p0          p1          cnt   err
    tbl[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5,      16'd0,      1'b1, 1'b1, 16'd5,      16'd0,      8'd1, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0,      16'd0,      1'b1, 1'b0, 16'd5,      16'd0,      8'd1, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1,      16'd10,     1'b1, 1'b0, 16'd5,      16'd0,      8'd1, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2,      -16'sd3,    1'b1, 1'b0, 16'd5,      16'd0,      8'd1, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3,      16'd7,      1'b1, 1'b1, 16'd6,      16'd14,     8'd3, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0,      16'd0,      1'b1, 1'b0, 16'd6,      16'd14,     8'd3, 1'b0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd20,     16'd0,      1'b1, 1'b1, 16'd20,     16'd0,      8'd1, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd99,     16'd1,      1'b0, 1'b1, 16'd20,     16'd0,      8'd1, 1'b0);
    tbl[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd99,     16'd1,      1'b0, 1'b1, 16'd20,     16'd0,      8'd1, 1'b0);
    tbl[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd99,     16'd1,      1'b0, 1'b1, 16'd20,     16'd0,      8'd1, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd99,     16'd1,      1'b0, 1'b1, 16'd20,     16'd0,      8'd1, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd9,      16'd0,      1'b1, 1'b1, 16'd9,      16'd0,      8'd1, 1'b0);
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd11,     16'd2,      1'b1, 1'b1, 16'd11,     16'd2,      8'd1, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0,      16'd0,      1'b1, 1'b0, 16'd11,     16'd2,      8'd1, 1'b0);
    tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4,      16'd0,      1'b1, 1'b0, 16'd11,     16'd2,      8'd1, 1'b0);
    tbl[15] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd6,      16'd0,      1'b1, 1'b1, 16'd6,      16'd0,      8'd1, 1'b1);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0,      16'd0,      1'b1, 1'b0, 16'd6,      16'd0,      8'd1, 1'b0);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd32767,  16'd0,      1'b1, 1'b0, 16'd6,      16'd0,      8'd1, 1'b0);
    tbl[18] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1,      16'd0,      1'b1, 1'b1, ovf_p0,     16'd0,      8'd2, ovf_err);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0,      16'd0,      1'b1, 1'b0, ovf_p0,     16'd0,      8'd2, 1'b0);
    tbl[20] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1,      16'd0,      1'b1, 1'b0, ovf_p0,     16'd0,      8'd2, 1'b0);
    tbl[21] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2,      16'd0,      1'b1, 1'b0, ovf_p0,     16'd0,      8'd2, 1'b1);
    tbl[22] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3,      16'd0,      1'b1, 1'b1, 16'd5,      16'd0,      8'd2, 1'b0);
    tbl[23] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0,      16'd0,      1'b1, 1'b0, 16'd5,      16'd0,      8'd2, 1'b0);

    i_rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    #1;
    chk_out("reset", 1'b0, 16'd0, 16'd0, 8'd0, 1'b0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step($sformatf("v%0d", i), tbl[i]);
    end

    // Mid-group reset with a pending protocol error: everything clears asynchronously.
    step("mr0", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0, 1'b1, 1'b0, 16'd5, 16'd0, 8'd2, 1'b0));
    step("mr1", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0, 1'b1, 1'b0, 16'd5, 16'd0, 8'd2, 1'b1));
    @(negedge i_clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    i_rst_n = 1'b0;
    #1;
    chk_out("mrst", 1'b0, 16'd0, 16'd0, 8'd0, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step("mr2", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0, 1'b1, 1'b1, 16'd3, 16'd0, 8'd1, 1'b0));
    step("mr3", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 16'd3, 16'd0, 8'd1, 1'b0));

    // Beat counter saturation: 256 beats of 1 close with count 255 and an error.
    @(negedge i_clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);
    for (int k = 0; k < 254; k++) begin
      @(negedge i_clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);
    end
    @(posedge i_clk);
    #1;
    chk_out("cnt255", 1'b0, 16'd3, 16'd0, 8'd1, 1'b0);
    step("cntsat", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 1'b1, 1'b1, 16'd256, 16'd0, 8'd255, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
